// File: rtl/muldiv_unit_pkg.sv
// Shared command codes, FSM encoding and helpers for the iterative multiply/divide unit.
// Every other file of the unit imports this package.
package muldiv_unit_pkg;

  localparam int XLEN        = 32;
  localparam int EXE_CMD_LEN = 4;

  typedef logic [EXE_CMD_LEN-1:0] exe_cmd_t;

  localparam exe_cmd_t EXE_ADD   = 4'd0;
  localparam exe_cmd_t EXE_SUB   = 4'd1;
  localparam exe_cmd_t EXE_MULT  = 4'd10;
  localparam exe_cmd_t EXE_DIVHI = 4'd11;
  localparam exe_cmd_t EXE_DIVLO = 4'd12;
  localparam exe_cmd_t EXE_MFHI  = 4'd13;
  localparam exe_cmd_t EXE_MFLO  = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } muldiv_state_t;

  // Everything about the operation that sign correction in FIN still needs.
  typedef struct packed {
    exe_cmd_t        cmd;
    logic            a_neg;
    logic            b_neg;
    logic            b_zero;
    logic [XLEN-1:0] a_raw;
  } muldiv_op_t;

  function automatic logic is_multi_cmd(input exe_cmd_t cmd);
    return (cmd == EXE_MULT) || (cmd == EXE_DIVHI) || (cmd == EXE_DIVLO);
  endfunction

  function automatic logic is_mf_cmd(input exe_cmd_t cmd);
    return (cmd == EXE_MFHI) || (cmd == EXE_MFLO);
  endfunction

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x);
    return x[XLEN-1] ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Pipeline-side bundle of the multiply/divide unit.
interface muldiv_unit_if;
  import muldiv_unit_pkg::*;

  // start is a one-cycle request sampled only in IDLE; busy stalls the
  // pipeline while an op is held, done pulses once when its result is valid.
  logic                 start;
  exe_cmd_t             exe_cmd;
  logic [XLEN-1:0]      val1;
  logic [XLEN-1:0]      val2;
  logic                 flush;
  logic                 busy;
  logic                 done;
  logic [XLEN-1:0]      result;
  logic [XLEN-1:0]      hi;
  logic [XLEN-1:0]      lo;
  muldiv_state_t        dbg_state;

  modport master (
    output start, exe_cmd, val1, val2, flush,
    input  busy, done, result, hi, lo, dbg_state
  );

  modport slave (
    input  start, exe_cmd, val1, val2, flush,
    output busy, done, result, hi, lo, dbg_state
  );

endinterface

// File: rtl/muldiv_core.sv
// 32-step unsigned datapath: shift-add multiply or restoring shift-subtract divide,
// one bit per step. {acc, sreg} holds the product, or remainder/quotient.
module muldiv_core
  import muldiv_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] a_mag,
  input  logic [XLEN-1:0] b_mag,
  output logic [XLEN-1:0] acc,
  output logic [XLEN-1:0] sreg,
  output logic            last
);

  logic [XLEN-1:0] breg;
  logic [4:0]      count;
  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;
  logic [XLEN-1:0] acc_nx;
  logic [XLEN-1:0] sreg_nx;

  always_comb begin
    add_sum = {1'b0, acc} + {1'b0, breg};
    shifted = {acc, sreg[XLEN-1]};
    diff    = {1'b0, shifted} - {2'b00, breg};
    acc_nx  = acc;
    sreg_nx = sreg;
    if (is_div) begin
      // Partial remainder stays below the divisor, so it always fits in 32 bits.
      if (!diff[XLEN+1]) begin
        acc_nx  = diff[XLEN-1:0];
        sreg_nx = {sreg[XLEN-2:0], 1'b1};
      end else begin
        acc_nx  = shifted[XLEN-1:0];
        sreg_nx = {sreg[XLEN-2:0], 1'b0};
      end
    end else if (sreg[0]) begin
      acc_nx  = add_sum[XLEN:1];
      sreg_nx = {add_sum[0], sreg[XLEN-1:1]};
    end else begin
      acc_nx  = {1'b0, acc[XLEN-1:1]};
      sreg_nx = {acc[0], sreg[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      sreg  <= '0;
      breg  <= '0;
      count <= '0;
    end else if (load) begin
      acc   <= '0;
      sreg  <= a_mag;
      breg  <= b_mag;
      count <= 5'd31;
    end else if (step) begin
      acc   <= acc_nx;
      sreg  <= sreg_nx;
      count <= count - 5'd1;
    end
  end

  assign last = (count == 5'd0);

endmodule

// File: rtl/muldiv_unit.sv
// EXE-stage multiply/divide unit: IDLE/CALC/FIN control, sign handling,
// architectural HI/LO and the result mux around the iterative core.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);

  muldiv_state_t   state;
  muldiv_state_t   state_nx;
  muldiv_op_t      op_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;

  logic            accept;
  logic            mf_read;
  logic            core_step;
  logic            core_last;
  logic            fin_write;
  logic [XLEN-1:0] core_acc;
  logic [XLEN-1:0] core_sreg;

  logic [2*XLEN-1:0] prod_mag;
  logic [2*XLEN-1:0] prod_signed;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fin_hi;
  logic [XLEN-1:0]   fin_lo;
  logic [XLEN-1:0]   fin_result;

  assign accept    = (state == ST_IDLE) && bus.start && is_multi_cmd(bus.exe_cmd) && !bus.flush;
  assign mf_read   = (state == ST_IDLE) && bus.start && is_mf_cmd(bus.exe_cmd);
  assign core_step = (state == ST_CALC) && !bus.flush;
  assign fin_write = (state == ST_FIN) && !bus.flush;

  muldiv_core u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .step   (core_step),
    .is_div (op_q.cmd != EXE_MULT),
    .a_mag  (magnitude(bus.val1)),
    .b_mag  (magnitude(bus.val2)),
    .acc    (core_acc),
    .sreg   (core_sreg),
    .last   (core_last)
  );

  always_comb begin
    state_nx = state;
    if (bus.flush) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept) state_nx = ST_CALC;
        ST_CALC: if (core_last) state_nx = ST_FIN;
        ST_FIN:  state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Sign correction: quotient negative when signs differ, remainder follows the dividend.
  always_comb begin
    prod_mag    = {core_acc, core_sreg};
    prod_signed = (op_q.a_neg ^ op_q.b_neg) ? (~prod_mag + 64'd1) : prod_mag;
    quo         = (op_q.a_neg ^ op_q.b_neg) ? (~core_sreg + 32'd1) : core_sreg;
    rem         = op_q.a_neg ? (~core_acc + 32'd1) : core_acc;
    fin_hi      = '0;
    fin_lo      = '0;
    if (op_q.cmd == EXE_MULT) begin
      fin_hi = prod_signed[2*XLEN-1:XLEN];
      fin_lo = prod_signed[XLEN-1:0];
    end else if (op_q.b_zero) begin
      fin_hi = op_q.a_raw;
      fin_lo = '1;
    end else begin
      fin_hi = rem;
      fin_lo = quo;
    end
    fin_result = (op_q.cmd == EXE_DIVHI) ? fin_hi : fin_lo;
  end

  always_comb begin
    bus.busy   = !rst && ((state == ST_CALC) ||
                          ((state == ST_IDLE) && bus.start && is_multi_cmd(bus.exe_cmd)));
    bus.done   = !rst && fin_write;
    bus.result = '0;
    if (!rst) begin
      if (fin_write) begin
        bus.result = fin_result;
      end else if (mf_read) begin
        bus.result = (bus.exe_cmd == EXE_MFHI) ? hi_q : lo_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      op_q  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q.cmd    <= bus.exe_cmd;
        op_q.a_neg  <= bus.val1[XLEN-1];
        op_q.b_neg  <= bus.val2[XLEN-1];
        op_q.b_zero <= (bus.val2 == '0);
        op_q.a_raw  <= bus.val1;
      end
      if (fin_write) begin
        hi_q <= fin_hi;
        lo_q <= fin_lo;
      end
    end
  end

  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table for full ops, hand sequences for
// flush, reset and ignored-start corner cases.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  muldiv_unit_if mif ();

  muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (mif)
  );

  typedef struct {
    exe_cmd_t    cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_result;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  localparam int NVEC = 12;
  vec_t        vecs[NVEC];
  logic [31:0] exp_q[$];
  int          checks;
  int          failures;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic advance(input int n);
    repeat (n) next_cycle();
  endtask

  task automatic drive_start(input exe_cmd_t cmd, input logic [31:0] a, input logic [31:0] b);
    mif.start   = 1'b1;
    mif.exe_cmd = cmd;
    mif.val1    = a;
    mif.val2    = b;
  endtask

  task automatic idle_inputs();
    mif.start   = 1'b0;
    mif.exe_cmd = EXE_ADD;
    mif.val1    = $urandom;
    mif.val2    = $urandom;
  endtask

  // Starts in the current cycle (cycle 0); returns at cycle 36 with inputs idle.
  task automatic run_vector(input vec_t v, input string tag);
    int   busy_cnt;
    logic early_done;
    busy_cnt   = 0;
    early_done = 1'b0;
    exp_q.push_back(v.exp_result);
    drive_start(v.cmd, v.a, v.b);
    @(negedge clk);
    if (mif.busy) busy_cnt++;
    if (mif.done) early_done = 1'b1;
    next_cycle();
    idle_inputs();
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (mif.busy) busy_cnt++;
      if (mif.done) early_done = 1'b1;
      next_cycle();
    end
    @(negedge clk);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
    check({tag, "_early_done"}, {31'd0, early_done}, 32'd0);
    check({tag, "_done"}, {31'd0, mif.done}, 32'd1);
    check({tag, "_busy_fin"}, {31'd0, mif.busy}, 32'd0);
    if (exp_q.size() > 0) check({tag, "_result"}, mif.result, exp_q.pop_front());
    next_cycle();
    drive_start(EXE_MFHI, $urandom, $urandom);
    @(negedge clk);
    check({tag, "_hi"}, mif.hi, v.exp_hi);
    check({tag, "_lo"}, mif.lo, v.exp_lo);
    check({tag, "_mfhi"}, mif.result, v.exp_hi);
    check({tag, "_mfhi_busy"}, {30'd0, mif.busy, mif.done}, 32'd0);
    next_cycle();
    mif.exe_cmd = EXE_MFLO;
    @(negedge clk);
    check({tag, "_mflo"}, mif.result, v.exp_lo);
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad;
    checks   = 0;
    failures = 0;
    rst       = 1'b1;
    mif.start = 1'b0;
    mif.exe_cmd = EXE_ADD;
    mif.val1  = '0;
    mif.val2  = '0;
    mif.flush = 1'b0;

    vecs[0]  = '{EXE_MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{EXE_DIVLO, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[2]  = '{EXE_DIVHI, 32'd100,      32'd0,        32'd100,      32'd100,      32'hFFFFFFFF};
    vecs[3]  = '{EXE_DIVLO, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        32'h80000000};
    vecs[4]  = '{EXE_MULT,  32'h80000000, 32'h80000000, 32'd0,        32'h40000000, 32'd0};
    vecs[5]  = '{EXE_MULT,  32'h12345678, 32'h10,       32'h23456780, 32'd1,        32'h23456780};
    vecs[6]  = '{EXE_DIVHI, 32'd7,        32'hFFFFFFFE, 32'd1,        32'd1,        32'hFFFFFFFD};
    vecs[7]  = '{EXE_DIVLO, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 32'd14};
    vecs[8]  = '{EXE_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd1};
    vecs[9]  = '{EXE_DIVHI, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[10] = '{EXE_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'd1,        32'h3FFFFFFF, 32'd1};
    vecs[11] = '{EXE_DIVLO, 32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 32'd0,        32'h7FFFFFFF};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, mif.busy}, 32'd0);
    check("rst_done", {31'd0, mif.done}, 32'd0);
    check("rst_result", mif.result, 32'd0);
    check("rst_hi", mif.hi, 32'd0);
    check("rst_lo", mif.lo, 32'd0);
    check("rst_state", {30'd0, mif.dbg_state}, {30'd0, ST_IDLE});
    next_cycle();

    for (int i = 0; i < NVEC; i++) run_vector(vecs[i], $sformatf("v%0d", i));

    // Non-muldiv command in IDLE is ignored.
    drive_start(EXE_ADD, 32'd3, 32'd4);
    @(negedge clk);
    check("add_busy", {31'd0, mif.busy}, 32'd0);
    check("add_done", {31'd0, mif.done}, 32'd0);
    check("add_result", mif.result, 32'd0);
    bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      @(negedge clk);
      if (mif.dbg_state != ST_IDLE || mif.done) bad = 1'b1;
    end
    check("add_stays_idle", {31'd0, bad}, 32'd0);
    next_cycle();
    idle_inputs();

    // New start requests during CALC must not disturb the op in flight.
    drive_start(EXE_MULT, 32'd6, 32'd7);
    next_cycle();
    idle_inputs();
    advance(4);
    drive_start(EXE_MULT, 32'd1000, 32'hFFFFFC18);
    next_cycle();
    drive_start(EXE_DIVLO, 32'd9, 32'd3);
    next_cycle();
    idle_inputs();
    advance(26);
    @(negedge clk);
    check("calc_start_done", {31'd0, mif.done}, 32'd1);
    check("calc_start_result", mif.result, 32'd42);
    next_cycle();
    @(negedge clk);
    check("calc_start_hi", mif.hi, 32'd0);
    check("calc_start_lo", mif.lo, 32'd42);

    // Flush in CALC at cycle 10, re-issue at cycle 12.
    drive_start(EXE_MULT, 32'd5, 32'd5);
    next_cycle();
    idle_inputs();
    advance(9);
    mif.flush = 1'b1;
    @(negedge clk);
    check("flush_c10_done", {31'd0, mif.done}, 32'd0);
    next_cycle();
    mif.flush = 1'b0;
    @(negedge clk);
    check("flush_c11_busy", {31'd0, mif.busy}, 32'd0);
    check("flush_c11_done", {31'd0, mif.done}, 32'd0);
    check("flush_c11_state", {30'd0, mif.dbg_state}, {30'd0, ST_IDLE});
    check("flush_c11_hi", mif.hi, 32'd0);
    check("flush_c11_lo", mif.lo, 32'd42);
    next_cycle();
    run_vector('{EXE_MULT, 32'd5, 32'd5, 32'd25, 32'd0, 32'd25}, "flush_remult");

    // Flush in FIN suppresses done and the HI/LO write.
    drive_start(EXE_DIVLO, 32'd50, 32'd7);
    next_cycle();
    idle_inputs();
    advance(32);
    mif.flush = 1'b1;
    @(negedge clk);
    check("fin_flush_done", {31'd0, mif.done}, 32'd0);
    check("fin_flush_result", mif.result, 32'd0);
    next_cycle();
    mif.flush = 1'b0;
    @(negedge clk);
    check("fin_flush_hi", mif.hi, 32'd0);
    check("fin_flush_lo", mif.lo, 32'd25);
    check("fin_flush_state", {30'd0, mif.dbg_state}, {30'd0, ST_IDLE});
    next_cycle();

    // Reset at cycle 20 of a divide, then a normal divide started at cycle 25.
    drive_start(EXE_DIVLO, 32'd1000, 32'd3);
    next_cycle();
    idle_inputs();
    advance(19);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'd0, mif.busy}, 32'd0);
    check("midrst_done", {31'd0, mif.done}, 32'd0);
    check("midrst_result", mif.result, 32'd0);
    check("midrst_hi", mif.hi, 32'd0);
    check("midrst_lo", mif.lo, 32'd0);
    check("midrst_state", {30'd0, mif.dbg_state}, {30'd0, ST_IDLE});
    advance(4);
    run_vector('{EXE_DIVLO, 32'd1000, 32'd3, 32'h14D, 32'd1, 32'h14D}, "post_rst");

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
